// File: rtl/prbs_pkg.sv
// Shared PRBS definitions used by both the checker and the generator side:
// polynomial select encoding, per-polynomial order and taps, checker states.
package prbs_pkg;

   localparam int LFSR_W = 31;

   typedef enum logic [1:0] {
      POLY_PRBS7  = 2'd0,
      POLY_PRBS15 = 2'd1,
      POLY_PRBS23 = 2'd2,
      POLY_PRBS31 = 2'd3
   } poly_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEED  = 2'd1,
      ST_CHECK = 2'd2,
      ST_LOST  = 2'd3
   } chk_state_e;

   function automatic logic [4:0] poly_order(poly_e p);
      case (p)
         POLY_PRBS7:  poly_order = 5'd7;
         POLY_PRBS15: poly_order = 5'd15;
         POLY_PRBS23: poly_order = 5'd23;
         default:     poly_order = 5'd31;
      endcase
   endfunction

   // Register bit k holds the stream bit from k+1 shifts ago, so x^n maps to bit n-1.
   function automatic logic [4:0] tap_hi(poly_e p);
      case (p)
         POLY_PRBS7:  tap_hi = 5'd6;
         POLY_PRBS15: tap_hi = 5'd14;
         POLY_PRBS23: tap_hi = 5'd22;
         default:     tap_hi = 5'd30;
      endcase
   endfunction

   function automatic logic [4:0] tap_lo(poly_e p);
      case (p)
         POLY_PRBS7:  tap_lo = 5'd5;
         POLY_PRBS15: tap_lo = 5'd13;
         POLY_PRBS23: tap_lo = 5'd17;
         default:     tap_lo = 5'd27;
      endcase
   endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Bit stream from the bit-rate NCO / receiver into the PRBS checker.
interface prbs_checker_if;
   logic bit_en;
   logic rx_bit;

   modport master (output bit_en, output rx_bit);
   modport slave  (input  bit_en, input  rx_bit);
endinterface

// File: rtl/prbs_tap_sel.sv
// Predicted next PRBS bit: XOR of the two tap positions of the selected polynomial.
module prbs_tap_sel
   import prbs_pkg::*;
(
   input  logic [LFSR_W-1:0] lfsr,
   input  poly_e             poly,
   output logic              pred_bit
);

   always_comb begin
      pred_bit = lfsr[tap_hi(poly)] ^ lfsr[tap_lo(poly)];
   end

endmodule

// File: rtl/prbs_checker.sv
// PRBS7/15/23/31 checker: self-seeds from the received stream, counts errors and
// checked bits, and drops lock on too many errors per window. Option: PRBS_CHK_AUTO_RESYNC_EN.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int ERR_CNT_W = 32,
   parameter int BIT_CNT_W = 48,
   parameter int WIN_LEN   = 64
) (
   input  logic                 dac_clk,
   input  logic                 reset_n,
   prbs_checker_if.slave        bit_if,
   input  logic                 chk_enable,
   input  logic [1:0]           poly_sel,
   input  logic                 clear_counters,
   input  logic [7:0]           lock_loss_thresh,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [BIT_CNT_W-1:0] bit_cnt,
   output logic [1:0]           state
);

   localparam int               WIN_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

   chk_state_e           state_q, state_d;
   poly_e                poly_q;
   logic [LFSR_W-1:0]    lfsr_q;
   logic [4:0]           seed_cnt_q;
   logic [WIN_W-1:0]     win_cnt_q;
   logic [7:0]           win_err_q;
   logic                 err_pulse_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic [BIT_CNT_W-1:0] bit_cnt_q;

   logic                 pred_bit;
   logic                 mismatch;
   logic                 seed_bit;
   logic                 check_bit;
   logic                 seed_last;
   logic                 seed_start;
   logic                 lose_lock;
   logic [LFSR_W-1:0]    seed_word;
   logic [8:0]           win_err_sum;

   prbs_tap_sel u_tap_sel (
      .lfsr     (lfsr_q),
      .poly     (poly_q),
      .pred_bit (pred_bit)
   );

   always_comb begin
      seed_word   = {lfsr_q[LFSR_W-2:0], bit_if.rx_bit};
      mismatch    = bit_if.rx_bit ^ pred_bit;
      seed_bit    = chk_enable && bit_if.bit_en && (state_q == ST_SEED);
      check_bit   = chk_enable && bit_if.bit_en && (state_q == ST_CHECK);
      seed_last   = (seed_cnt_q == (poly_order(poly_q) - 5'd1));
      win_err_sum = {1'b0, win_err_q} + {8'd0, mismatch};
      lose_lock   = (lock_loss_thresh != 8'd0) && (win_err_sum >= {1'b0, lock_loss_thresh});
   end

   // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      seed_start = 1'b0;
      if (!chk_enable) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d    = ST_SEED;
               seed_start = 1'b1;
            end
            ST_SEED: begin
               // An all-zero seed would lock the LFSR at zero, so it just restarts seeding.
               if (seed_bit && seed_last && (seed_word != '0)) state_d = ST_CHECK;
            end
            ST_CHECK: begin
               if (check_bit && lose_lock) state_d = ST_LOST;
            end
            ST_LOST: begin
`ifdef PRBS_CHK_AUTO_RESYNC_EN
               state_d    = ST_SEED;
               seed_start = 1'b1;
`else
               state_d    = ST_LOST;
`endif
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge dac_clk) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge dac_clk) begin
      if (!reset_n) begin
         poly_q      <= POLY_PRBS7;
         lfsr_q      <= '0;
         seed_cnt_q  <= '0;
         win_cnt_q   <= '0;
         win_err_q   <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         err_pulse_q <= 1'b0;
         if (seed_start) begin
            poly_q     <= poly_e'(poly_sel);
            lfsr_q     <= '0;
            seed_cnt_q <= '0;
            win_cnt_q  <= '0;
            win_err_q  <= '0;
         end else if (seed_bit) begin
            lfsr_q     <= seed_word;
            seed_cnt_q <= seed_last ? 5'd0 : seed_cnt_q + 5'd1;
         end else if (check_bit) begin
            lfsr_q      <= {lfsr_q[LFSR_W-2:0], pred_bit};
            err_pulse_q <= mismatch;
            if (win_cnt_q == WIN_LAST) begin
               win_cnt_q <= '0;
               win_err_q <= '0;
            end else begin
               win_cnt_q <= win_cnt_q + WIN_W'(1);
               win_err_q <= win_err_sum[8] ? 8'hFF : win_err_sum[7:0];
            end
         end
      end
   end

   always_ff @(posedge dac_clk) begin
      if (!reset_n || clear_counters) begin
         err_cnt_q <= '0;
         bit_cnt_q <= '0;
      end else begin
         if (check_bit && (bit_cnt_q != '1)) bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
         if (check_bit && mismatch && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
   end

   assign locked    = (state_q == ST_CHECK);
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;
   assign bit_cnt   = bit_cnt_q;
   assign state     = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker; a second narrow-counter instance on the same stimulus
// makes counter saturation reachable in a short run.
module tb_prbs_checker;

   logic        dac_clk = 1'b0;
   logic        reset_n;
   logic        chk_enable;
   logic [1:0]  poly_sel;
   logic        clear_counters;
   logic [7:0]  lock_loss_thresh;

   logic        locked, err_pulse;
   logic [31:0] err_cnt;
   logic [47:0] bit_cnt;
   logic [1:0]  state;

   logic        s_locked, s_err_pulse;
   logic [1:0]  s_err_cnt;
   logic [3:0]  s_bit_cnt;
   logic [1:0]  s_state;

   prbs_checker_if bus ();

   prbs_checker dut (
      .dac_clk          (dac_clk),
      .reset_n          (reset_n),
      .bit_if           (bus),
      .chk_enable       (chk_enable),
      .poly_sel         (poly_sel),
      .clear_counters   (clear_counters),
      .lock_loss_thresh (lock_loss_thresh),
      .locked           (locked),
      .err_pulse        (err_pulse),
      .err_cnt          (err_cnt),
      .bit_cnt          (bit_cnt),
      .state            (state)
   );

   prbs_checker #(.ERR_CNT_W(2), .BIT_CNT_W(4), .WIN_LEN(64)) dut_sat (
      .dac_clk          (dac_clk),
      .reset_n          (reset_n),
      .bit_if           (bus),
      .chk_enable       (chk_enable),
      .poly_sel         (poly_sel),
      .clear_counters   (clear_counters),
      .lock_loss_thresh (lock_loss_thresh),
      .locked           (s_locked),
      .err_pulse        (s_err_pulse),
      .err_cnt          (s_err_cnt),
      .bit_cnt          (s_bit_cnt),
      .state            (s_state)
   );

   always #5 dac_clk = ~dac_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int pulse_cnt = 0;

   always @(negedge dac_clk) if (err_pulse) pulse_cnt++;

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Reference generator, built directly from the polynomial exponents.
   logic [30:0] gen;
   int          gen_ord, gen_tap;

   task automatic gen_init(input int p);
      gen = '1;
      case (p)
         0: begin gen_ord = 7;  gen_tap = 6;  end
         1: begin gen_ord = 15; gen_tap = 14; end
         2: begin gen_ord = 23; gen_tap = 18; end
         default: begin gen_ord = 31; gen_tap = 28; end
      endcase
   endtask

   task automatic gen_next(output logic b);
      b   = gen[gen_ord-1] ^ gen[gen_tap-1];
      gen = {gen[29:0], b};
   endtask

   task automatic tick();
      @(posedge dac_clk);
      #1;
   endtask

   logic       last_pulse;
   logic [1:0] last_state, next_state;

   // One bit every 4 cycles; records err_pulse/state right after the bit edge and one edge later.
   task automatic send_bit(input logic b, input logic clr);
      bus.bit_en     = 1'b1;
      bus.rx_bit     = b;
      clear_counters = clr;
      tick();
      bus.bit_en     = 1'b0;
      clear_counters = 1'b0;
      last_pulse     = err_pulse;
      last_state     = state;
      tick();
      next_state     = state;
      tick();
      tick();
   endtask

   task automatic send_gen(input int n, input logic inv);
      logic b;
      for (int i = 0; i < n; i++) begin
         gen_next(b);
         send_bit(b ^ inv, 1'b0);
      end
   endtask

   task automatic start_poly(input int p);
      chk_enable = 1'b0;
      tick();
      poly_sel   = 2'(p);
      chk_enable = 1'b1;
      tick();
      gen_init(p);
   endtask

   task automatic clear_cnt();
      clear_counters = 1'b1;
      tick();
      clear_counters = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  base;
      logic b;
      reset_n          = 1'b0;
      chk_enable       = 1'b0;
      poly_sel         = 2'd0;
      clear_counters   = 1'b0;
      lock_loss_thresh = 8'd8;
      bus.bit_en       = 1'b0;
      bus.rx_bit       = 1'b0;
      gen_init(0);
      repeat (3) tick();

      check("rst_state", 64'(state), 64'd0);
      check("rst_locked", 64'(locked), 64'd0);
      check("rst_err_pulse", 64'(err_pulse), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      check("rst_bit_cnt", 64'(bit_cnt), 64'd0);
      reset_n = 1'b1;
      tick();

      // PRBS7 error-free
      start_poly(0);
      check("p7_seed_state", 64'(state), 64'd1);
      send_gen(6, 1'b0);
      check("p7_locked_after6", 64'(locked), 64'd0);
      send_gen(1, 1'b0);
      check("p7_locked_after7", 64'(locked), 64'd1);
      check("p7_seed_not_counted", 64'(bit_cnt), 64'd0);
      base = pulse_cnt;
      send_gen(1000, 1'b0);
      check("p7_err_cnt", 64'(err_cnt), 64'd0);
      check("p7_bit_cnt", 64'(bit_cnt), 64'd1000);
      check("p7_pulses", 64'(pulse_cnt - base), 64'd0);
      check("sat_bit_cnt_held", 64'(s_bit_cnt), 64'hF);

      // chk_enable=0 -> IDLE, counters held, bit_en ignored
      chk_enable = 1'b0;
      tick();
      check("dis_state", 64'(state), 64'd0);
      check("dis_locked", 64'(locked), 64'd0);
      send_bit(1'b1, 1'b0);
      check("dis_bit_cnt_held", 64'(bit_cnt), 64'd1000);

      // PRBS31 with three injected errors; poly_sel change during CHECK ignored
      start_poly(3);
      clear_cnt();
      lock_loss_thresh = 8'd8;
      send_gen(31, 1'b0);
      check("p31_locked", 64'(locked), 64'd1);
      poly_sel = 2'd0;
      base = pulse_cnt;
      for (int i = 1; i <= 300; i++) begin
         logic inj;
         inj = (i == 100) || (i == 200) || (i == 300);
         gen_next(b);
         send_bit(b ^ inj, 1'b0);
         if (inj) check($sformatf("p31_pulse_bit%0d", i), 64'(last_pulse), 64'd1);
      end
      check("p31_pulses", 64'(pulse_cnt - base), 64'd3);
      check("p31_err_cnt", 64'(err_cnt), 64'd3);
      check("p31_bit_cnt", 64'(bit_cnt), 64'd300);
      check("p31_still_locked", 64'(locked), 64'd1);

      // PRBS15 loss of lock with thresh=4
      start_poly(1);
      clear_cnt();
      lock_loss_thresh = 8'd4;
      send_gen(15, 1'b0);
      check("p15_locked", 64'(locked), 64'd1);
      send_gen(3, 1'b1);
      check("p15_state_after3", 64'(state), 64'd2);
      send_gen(1, 1'b1);
      check("p15_lost_on_4th", 64'(last_state), 64'd3);
      check("p15_err_cnt", 64'(err_cnt), 64'd4);
`ifdef PRBS_CHK_AUTO_RESYNC_EN
      check("p15_resync_seed", 64'(next_state), 64'd1);
      send_gen(14, 1'b0);
      check("p15_not_yet_relocked", 64'(locked), 64'd0);
      send_gen(1, 1'b0);
      check("p15_relocked", 64'(state), 64'd2);
`else
      check("p15_lost_held", 64'(next_state), 64'd3);
      send_gen(20, 1'b0);
      check("p15_lost_still_held", 64'(state), 64'd3);
      chk_enable = 1'b0;
      tick();
      check("p15_lost_to_idle", 64'(state), 64'd0);
`endif

      // PRBS23 all-zero seed never locks; a real stream then locks
      start_poly(2);
      clear_cnt();
      lock_loss_thresh = 8'd0;
      for (int i = 0; i < 46; i++) send_bit(1'b0, 1'b0);
      check("p23_zero_state", 64'(state), 64'd1);
      check("p23_zero_unlocked", 64'(locked), 64'd0);
      check("p23_zero_bit_cnt", 64'(bit_cnt), 64'd0);
      send_gen(23, 1'b0);
      check("p23_locked", 64'(locked), 64'd1);

      // Saturation on the narrow instance, loss disabled by thresh=0
      send_gen(5, 1'b1);
      check("sat_wide_err_cnt", 64'(err_cnt), 64'd5);
      check("sat_narrow_err_cnt", 64'(s_err_cnt), 64'd3);
      check("sat_no_loss", 64'(state), 64'd2);
      check("sat_narrow_bit_cnt", 64'(s_bit_cnt), 64'd5);
      gen_next(b);
      send_bit(~b, 1'b1);
      check("clr_pulse_still", 64'(last_pulse), 64'd1);
      check("clr_err_cnt", 64'(err_cnt), 64'd0);
      check("clr_narrow_err_cnt", 64'(s_err_cnt), 64'd0);
      check("clr_bit_cnt", 64'(bit_cnt), 64'd0);

      // Reset mid-CHECK with an erroneous bit in the reset cycle
      send_gen(3, 1'b0);
      gen_next(b);
      poly_sel   = 2'd0;
      bus.bit_en = 1'b1;
      bus.rx_bit = ~b;
      reset_n    = 1'b0;
      tick();
      bus.bit_en = 1'b0;
      reset_n    = 1'b1;
      check("mid_rst_state", 64'(state), 64'd0);
      check("mid_rst_locked", 64'(locked), 64'd0);
      check("mid_rst_err_pulse", 64'(err_pulse), 64'd0);
      check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
      check("mid_rst_bit_cnt", 64'(bit_cnt), 64'd0);
      tick();
      check("mid_rst_seed", 64'(state), 64'd1);
      gen_init(0);
      send_gen(7, 1'b0);
      check("mid_rst_relock", 64'(locked), 64'd1);
      send_gen(10, 1'b0);
      check("mid_rst_err_free", 64'(err_cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 32: error counter width.
REQ-002 SHALL have parameter BIT_CNT_W, default 48: checked-bit counter width.
REQ-003 SHALL have parameter WIN_LEN, default 64: lock-monitor window length, in checked bits.
REQ-004 SHALL have port dac_clk  in  1: the only clock. Single clock domain; all logic on the rising edge.
REQ-005 SHALL have port reset_n  in  1: reset, synchronous and active-low.
REQ-006 SHALL have port chk_enable  in  1: checker run; 0 forces IDLE.
REQ-007 SHALL have port poly_sel  in  2: polynomial select. 0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31.
REQ-008 SHALL have port bit_en  in  1: one-cycle bit strobe from the bit-rate NCO.
REQ-009 SHALL have port rx_bit  in  1: received data bit, valid when bit_en=1.
REQ-010 SHALL have port clear_counters  in  1: synchronous clear of err_cnt and bit_cnt.
REQ-011 SHALL have port lock_loss_thresh  in  8: error count within one window that declares loss of lock.
REQ-012 SHALL have port locked  out  1: high while the state is CHECK.
REQ-013 SHALL have port err_pulse  out  1: one-cycle pulse per mismatched bit.
REQ-014 SHALL have port err_cnt  out  ERR_CNT_W: saturating error count.
REQ-015 SHALL have port bit_cnt  out  BIT_CNT_W: saturating count of checked bits.
REQ-016 SHALL have port state  out  2: current state. IDLE=0, SEED=1, CHECK=2, LOST=3.

Function
REQ-017 SHALL implement Fibonacci LFSRs in a 31-bit register, with each new bit entering at bit 0.
- Taps: PRBS7 x^7+x^6+1; PRBS15 x^15+x^14+1; PRBS23 x^23+x^18+1; PRBS31 x^31+x^28+1.
- Predicted bit = XOR of the two tap positions.
REQ-018 SHALL latch poly_sel only on the IDLE->SEED and LOST->SEED transitions; poly_sel changes at any other time are ignored.
REQ-019 SHALL move IDLE->SEED on the first cycle with chk_enable=1.
REQ-020 In SEED, SHALL shift rx_bit into the register on each bit_en.
- After N seeded bits (N = polynomial order), go to CHECK.
- If the seeded bits are all zero, restart seeding instead.
REQ-021 In CHECK, on each bit_en, SHALL compare rx_bit with the predicted bit and shift the predicted bit (not rx_bit) into the register.
REQ-022 On a mismatch, SHALL assert err_pulse for exactly the cycle after the bit_en cycle, and increment err_cnt on that same edge.
REQ-023 SHALL increment bit_cnt once per checked bit in CHECK; SEED bits are not counted.
REQ-024 SHALL saturate err_cnt and bit_cnt at all-ones; they never wrap.
REQ-025 Lock monitor: window counter runs 0..WIN_LEN-1 over checked bits; window error counter is cleared at window wrap.
- When window errors reach lock_loss_thresh, go CHECK->LOST.
- lock_loss_thresh=0 disables loss detection.
REQ-026 clear_counters SHALL take priority over a same-cycle increment, leaving both counters at 0 on that edge.
REQ-027 chk_enable=0 in any state SHALL force IDLE on the next edge; err_cnt and bit_cnt hold their values.
REQ-028 bit_en outside SEED/CHECK SHALL be ignored.
REQ-029 locked SHALL deassert on the same edge the state leaves CHECK.

Reset
REQ-030 With reset_n=0 at a dac_clk edge, the following SHALL be set:
- state=IDLE; locked=0; err_pulse=0; err_cnt=0; bit_cnt=0.
- LFSR register, window counters and latched poly_sel all zero.
REQ-031 Reset asserted mid-CHECK SHALL abandon lock; no err_pulse is generated in the reset cycle.

Configuration
REQ-032 With macro PRBS_CHK_AUTO_RESYNC_EN defined, LOST SHALL move to SEED on the next edge (re-latching poly_sel) and the window counters SHALL clear.
REQ-033 Without PRBS_CHK_AUTO_RESYNC_EN, LOST SHALL be held until chk_enable=0, after which the normal IDLE->SEED sequence applies.

Structure
REQ-034 Package prbs_pkg SHALL hold the following, shared with the PRBS generator side:
- poly_sel encoding constants;
- tap positions and order per polynomial;
- the state enumeration.
REQ-035 Combinational sub-module prbs_tap_sel SHALL map (register, latched poly_sel) to the predicted bit.
REQ-036 The FSM, counters and lock monitor SHALL reside in prbs_checker.

Verification
REQ-037 PRBS7, error-free stream, bit_en every 4 cycles:
- locked=1 after 7 bit_en;
- after 1000 further bits, err_cnt=0 and bit_cnt=1000.
REQ-038 PRBS31 locked, rx_bit inverted on checked bits 100, 200 and 300:
- exactly 3 err_pulse, each 1 cycle after the corresponding bit_en;
- err_cnt=3; locked stays 1 with thresh=8.
REQ-039 PRBS15 locked, thresh=4, stream replaced by inverted data:
- LOST reached after the 4th error in the window;
- with PRBS_CHK_AUTO_RESYNC_EN: SEED next cycle and relock after 15 good bits;
- without it: state holds at 3 until chk_enable=0.
REQ-040 All-zero rx_bit during SEED (PRBS23): state stays SEED and never asserts locked.
REQ-041 Preload err_cnt to 32'hFFFF_FFFE, inject 3 errors:
- err_cnt=32'hFFFF_FFFF, held;
- clear_counters coincident with an error -> err_cnt=0.
REQ-042 reset_n=0 mid-CHECK for one cycle: all outputs at reset values on the next edge; resync from SEED once chk_enable=1.
